// File: rtl/cmode_tx.sv
// Serial mode-word transmitter: start, MSB-first data, optional parity, stop, with a mid-bit bclko strobe.
// Define CMODE_TX_PARITY_EN to include the even-parity bit in each frame.
module cmode_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mode_data,
    input  logic              mode_valid,
    output logic              mode_ready,
    output logic              cmode,
    output logic              bclko,
    output logic              busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef CMODE_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift;
`ifdef CMODE_TX_PARITY_EN
    logic              parity_bit;
`endif
    logic              accept;
    logic              bit_end;
    logic              cmode_d;
    logic              bclko_d;
    logic              busy_d;

    assign accept  = mode_valid && mode_ready;
    assign bit_end = (cnt == CNT_LAST);

    // Outputs are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef CMODE_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            mode_ready <= 1'b0;
            cmode      <= 1'b1;
            bclko      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            mode_ready <= (next_state == IDLE);
            cmode      <= cmode_d;
            bclko      <= bclko_d;
            busy       <= busy_d;

            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
            end

            if (accept) begin
                shift <= mode_data;
            end else if (state == DATA && bit_end) begin
                shift <= shift << 1;
            end

`ifdef CMODE_TX_PARITY_EN
            if (accept) begin
                parity_bit <= ^mode_data;
            end
`endif
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept)  next_state = START;
            START:  if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end && bit_idx == BIT_LAST) begin
`ifdef CMODE_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef CMODE_TX_PARITY_EN
            PARITY: if (bit_end) next_state = STOP;
`endif
            STOP:   if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmode_d = 1'b1;
        case (state)
            START:  cmode_d = 1'b0;
            DATA:   cmode_d = shift[DATA_W-1];
`ifdef CMODE_TX_PARITY_EN
            PARITY: cmode_d = parity_bit;
`endif
            default: cmode_d = 1'b1;
        endcase
        bclko_d = (state != IDLE) && (cnt >= CNT_HALF);
        busy_d  = (state != IDLE);
    end

endmodule

// File: tb/tb_cmode_tx.sv
// Self-checking bench for cmode_tx: random and directed words checked against a frame-level model.
module tb_cmode_tx;

    localparam int DW = 8;
    localparam int BC = 4;
`ifdef CMODE_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB    = DW + 2 + PAR;
    localparam int FRAME = NB * BC;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] mode_data;
    logic          mode_valid;
    logic          mode_ready;
    logic          cmode;
    logic          bclko;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [NB-1:0] cap;

    cmode_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .sysclk    (clk),
        .rst_n     (rst_n),
        .mode_data (mode_data),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .cmode     (cmode),
        .bclko     (bclko),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot i of the frame: start, data MSB first, optional even parity, stop.
    function automatic logic [NB-1:0] frame_bits(input logic [DW-1:0] w);
        logic [NB-1:0] v;
        v    = '0;
        v[0] = 1'b0;
        for (int i = 0; i < DW; i++) v[1+i] = w[DW-1-i];
        if (PAR == 1) v[DW+1] = ^w;
        v[NB-1] = 1'b1;
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mode_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL wait_ready got=timeout exp=mode_ready");
        end
    endtask

    // Sends one word and checks {busy,mode_ready,cmode,bclko} every cycle of the frame.
    task automatic run_frame(input logic [DW-1:0] w, input int pulse_k, input int rst_k, input string name);
        logic [NB-1:0] eb;
        logic [3:0]    got;
        logic [3:0]    exp;
        bit            ok;
        eb = frame_bits(w);
        wait_ready(ok);
        if (!ok) return;
        mode_data  = w;
        mode_valid = 1'b1;
        @(negedge clk);
        mode_valid = 1'b0;
        n_cmp++;
        if ({busy, mode_ready, cmode} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL %s accept got=%b exp=001", name, {busy, mode_ready, cmode});
        end
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            got = {busy, mode_ready, cmode, bclko};
            if (k <= FRAME) begin
                exp = {1'b1, (k == FRAME), eb[(k-1)/BC], (((k-1) % BC) >= BC/2)};
                if (((k-1) % BC) == BC/2) cap[(k-1)/BC] = cmode;
            end else begin
                exp = 4'b0110;
            end
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s k=%0d got=%b exp=%b", name, k, got, exp);
            end
            if (k == pulse_k) begin
                mode_data  = 8'hFF;
                mode_valid = 1'b1;
            end
            if (k == pulse_k + 1) begin
                mode_valid = 1'b0;
                mode_data  = w;
            end
            if (k == rst_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                n_cmp++;
                if ({busy, mode_ready, cmode, bclko} !== 4'b0010) begin
                    n_fail++;
                    $display("[TB] FAIL %s reset got=%b exp=0010", name, {busy, mode_ready, cmode, bclko});
                end
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        mode_valid = 1'b0;
        mode_data  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, mode_ready, cmode, bclko} !== 4'b0010) begin
                n_fail++;
                $display("[TB] FAIL reset_hold got=%b exp=0010", {busy, mode_ready, cmode, bclko});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, mode_ready, cmode, bclko} !== 4'b0110) begin
            n_fail++;
            $display("[TB] FAIL reset_release got=%b exp=0110", {busy, mode_ready, cmode, bclko});
        end
    endtask

    task automatic test_single();
        run_frame(8'hA5, -1, -1, "single_A5");
    endtask

    task automatic test_parity();
        run_frame(8'h07, -1, -1, "parity_07");
        n_cmp++;
        if (cap[DW+1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL parity_slot got=%b exp=1", cap[DW+1]);
        end
    endtask

    task automatic test_back_to_back();
        bit            ok;
        int            acc2;
        logic          prev_b;
        logic [1:0]    gap;
        logic [NB-1:0] g1;
        logic [NB-1:0] g2;
        logic          rx[$];
        wait_ready(ok);
        if (!ok) return;
        mode_data  = 8'h3C;
        mode_valid = 1'b1;
        @(negedge clk);
        mode_data = 8'hC3;
        acc2      = -1;
        prev_b    = bclko;
        gap       = 2'bxx;
        for (int k = 1; k <= 2 * FRAME + 4; k++) begin
            @(negedge clk);
            if (bclko === 1'b1 && prev_b === 1'b0) rx.push_back(cmode);
            prev_b = bclko;
            if (acc2 > 0 && k == acc2) mode_valid = 1'b0;
            if (acc2 < 0 && mode_ready === 1'b1 && mode_valid) acc2 = k + 1;
            if (k == FRAME + 1) gap = {busy, cmode};
        end
        mode_valid = 1'b0;
        n_cmp++;
        if (acc2 !== FRAME + 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept got=%0d exp=%0d", acc2, FRAME + 1);
        end
        n_cmp++;
        if (gap !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL b2b_gap got=%b exp=01", gap);
        end
        n_cmp++;
        if (rx.size() != 2 * NB) begin
            n_fail++;
            $display("[TB] FAIL b2b_rx_count got=%0d exp=%0d", rx.size(), 2 * NB);
        end
        for (int i = 0; i < NB; i++) begin
            g1[i] = (i < rx.size()) ? rx[i] : 1'bx;
            g2[i] = (NB + i < rx.size()) ? rx[NB+i] : 1'bx;
        end
        n_cmp++;
        if (g1 !== frame_bits(8'h3C)) begin
            n_fail++;
            $display("[TB] FAIL b2b_frame1 got=%b exp=%b", g1, frame_bits(8'h3C));
        end
        n_cmp++;
        if (g2 !== frame_bits(8'hC3)) begin
            n_fail++;
            $display("[TB] FAIL b2b_frame2 got=%b exp=%b", g2, frame_bits(8'hC3));
        end
    endtask

    task automatic test_midframe_valid();
        logic seen;
        run_frame(8'h55, 10, -1, "pulse_55");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cmode !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pulse_no_ff got=%b exp=0", seen);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(8'hF0, -1, 20, "reset_F0");
        run_frame(8'h81, -1, -1, "after_reset_81");
    endtask

    task automatic test_reset_accept();
        bit   ok;
        logic seen;
        wait_ready(ok);
        if (!ok) return;
        mode_data  = 8'h99;
        mode_valid = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, mode_ready, cmode, bclko} !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL reset_accept got=%b exp=0010", {busy, mode_ready, cmode, bclko});
        end
        rst_n      = 1'b1;
        mode_valid = 1'b0;
        seen       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cmode !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_accept_idle got=%b exp=0", seen);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        for (int i = 0; i < 6; i++) begin
            w = DW'($urandom_range(0, (1 << DW) - 1));
            run_frame(w, -1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_midframe_valid();
        test_mid_reset();
        test_reset_accept();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
